// File: rtl/rx_eth_hdr_strip.sv
// Ethernet RX header stripper: captures the 14-byte header into sideband registers,
// drops runt frames and re-aligns the payload to byte lane 0 on a registered AXI-stream.
module rx_eth_hdr_strip #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  axis_resetn,
    input  logic [DATA_WIDTH-1:0] s_rx_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_rx_axis_tkeep,
    input  logic                  s_rx_axis_tvalid,
    input  logic                  s_rx_axis_tlast,
    input  logic                  s_rx_axis_tuser,
    output logic                  s_rx_axis_tready,
    output logic [DATA_WIDTH-1:0] m_pl_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_pl_axis_tkeep,
    output logic                  m_pl_axis_tvalid,
    output logic                  m_pl_axis_tlast,
    output logic                  m_pl_axis_tuser,
    input  logic                  m_pl_axis_tready,
    output logic [47:0]           hdr_dst_mac,
    output logic [47:0]           hdr_src_mac,
    output logic [15:0]           hdr_len_type,
    output logic                  hdr_valid,
    output logic [31:0]           frame_cnt,
    output logic [15:0]           runt_cnt
);

    typedef enum logic [1:0] {
        HDR0  = 2'd0,
        HDR1  = 2'd1,
        BODY  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           res_q, res_d;
    logic [1:0]            resKeep_q, resKeep_d;
    logic                  tuserLatch_q, tuserLatch_d;
    logic [47:0]           dstStage_q, dstStage_d;
    logic [15:0]           srcLoStage_q, srcLoStage_d;
    logic [DATA_WIDTH-1:0] outData_q, outData_d;
    logic [KEEP_WIDTH-1:0] outKeep_q, outKeep_d;
    logic                  outValid_q, outValid_d;
    logic                  outLast_q, outLast_d;
    logic                  outUser_q, outUser_d;
    logic [47:0]           hdrDst_q, hdrDst_d;
    logic [47:0]           hdrSrc_q, hdrSrc_d;
    logic [15:0]           hdrLen_q, hdrLen_d;
    logic                  hdrValid_q, hdrValid_d;
    logic [31:0]           frameCnt_q, frameCnt_d;
    logic [15:0]           runtCnt_q, runtCnt_d;

    logic                  ld;
    logic                  inReady;
    logic                  inAccept;
    logic                  runtHit;

    // Lanes whose keep bit is clear are forced to zero so stale residue never leaks out.
    function automatic logic [DATA_WIDTH-1:0] maskBytes(
        input logic [DATA_WIDTH-1:0] data,
        input logic [KEEP_WIDTH-1:0] keep
    );
        logic [DATA_WIDTH-1:0] masked;
        masked = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            if (keep[i]) begin
                masked[8*i +: 8] = data[8*i +: 8];
            end
        end
        return masked;
    endfunction

    always_ff @(posedge clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q      <= HDR0;
            res_q        <= '0;
            resKeep_q    <= '0;
            tuserLatch_q <= 1'b0;
            dstStage_q   <= '0;
            srcLoStage_q <= '0;
            outData_q    <= '0;
            outKeep_q    <= '0;
            outValid_q   <= 1'b0;
            outLast_q    <= 1'b0;
            outUser_q    <= 1'b0;
            hdrDst_q     <= '0;
            hdrSrc_q     <= '0;
            hdrLen_q     <= '0;
            hdrValid_q   <= 1'b0;
            frameCnt_q   <= '0;
            runtCnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            res_q        <= res_d;
            resKeep_q    <= resKeep_d;
            tuserLatch_q <= tuserLatch_d;
            dstStage_q   <= dstStage_d;
            srcLoStage_q <= srcLoStage_d;
            outData_q    <= outData_d;
            outKeep_q    <= outKeep_d;
            outValid_q   <= outValid_d;
            outLast_q    <= outLast_d;
            outUser_q    <= outUser_d;
            hdrDst_q     <= hdrDst_d;
            hdrSrc_q     <= hdrSrc_d;
            hdrLen_q     <= hdrLen_d;
            hdrValid_q   <= hdrValid_d;
            frameCnt_q   <= frameCnt_d;
            runtCnt_q    <= runtCnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        res_d        = res_q;
        resKeep_d    = resKeep_q;
        tuserLatch_d = tuserLatch_q;
        dstStage_d   = dstStage_q;
        srcLoStage_d = srcLoStage_q;
        outData_d    = outData_q;
        outKeep_d    = outKeep_q;
        outValid_d   = outValid_q;
        outLast_d    = outLast_q;
        outUser_d    = outUser_q;
        hdrDst_d     = hdrDst_q;
        hdrSrc_d     = hdrSrc_q;
        hdrLen_d     = hdrLen_q;
        hdrValid_d   = 1'b0;
        frameCnt_d   = frameCnt_q;
        runtCnt_d    = runtCnt_q;
        runtHit      = 1'b0;

        ld = !outValid_q || m_pl_axis_tready;

        case (state_q)
            BODY:    inReady = ld;
            FLUSH:   inReady = 1'b0;
            default: inReady = 1'b1;
        endcase
        inAccept = s_rx_axis_tvalid && inReady;

        // The output slot empties when consumed; a load below overrides this.
        if (ld) begin
            outValid_d = 1'b0;
        end

        case (state_q)
            HDR0: begin
                if (inAccept) begin
                    dstStage_d   = s_rx_axis_tdata[47:0];
                    srcLoStage_d = s_rx_axis_tdata[63:48];
                    if (s_rx_axis_tlast) begin
                        runtHit = 1'b1;
                    end else begin
                        state_d = HDR1;
                    end
                end
            end

            HDR1: begin
                if (inAccept) begin
                    res_d        = s_rx_axis_tdata[63:48];
                    resKeep_d    = s_rx_axis_tkeep[7:6];
                    tuserLatch_d = s_rx_axis_tuser;
                    if ((s_rx_axis_tkeep[5:0] != 6'h3F) ||
                        (s_rx_axis_tlast && (s_rx_axis_tkeep[7:6] == 2'b00))) begin
                        runtHit = 1'b1;
                        state_d = HDR0;
                    end else begin
                        hdrDst_d   = dstStage_q;
                        hdrSrc_d   = {s_rx_axis_tdata[31:0], srcLoStage_q};
                        hdrLen_d   = s_rx_axis_tdata[47:32];
                        hdrValid_d = 1'b1;
                        state_d    = s_rx_axis_tlast ? FLUSH : BODY;
                    end
                end
            end

            BODY: begin
                if (inAccept) begin
                    outValid_d = 1'b1;
                    outKeep_d  = {s_rx_axis_tkeep[5:0], resKeep_q};
                    outData_d  = maskBytes({s_rx_axis_tdata[47:0], res_q},
                                           {s_rx_axis_tkeep[5:0], resKeep_q});
                    res_d      = s_rx_axis_tdata[63:48];
                    resKeep_d  = s_rx_axis_tkeep[7:6];
                    outLast_d  = 1'b0;
                    outUser_d  = 1'b0;
                    if (s_rx_axis_tlast) begin
                        if (s_rx_axis_tkeep[7:6] == 2'b00) begin
                            outLast_d = 1'b1;
                            outUser_d = s_rx_axis_tuser;
                            state_d   = HDR0;
                        end else begin
                            tuserLatch_d = s_rx_axis_tuser;
                            state_d      = FLUSH;
                        end
                    end
                end
            end

            FLUSH: begin
                if (ld) begin
                    outValid_d = 1'b1;
                    outKeep_d  = {6'h00, resKeep_q};
                    outData_d  = maskBytes({48'h0, res_q}, {6'h00, resKeep_q});
                    outLast_d  = 1'b1;
                    outUser_d  = tuserLatch_q;
                    state_d    = HDR0;
                end
            end

            default: state_d = HDR0;
        endcase

        if (outValid_q && m_pl_axis_tready && outLast_q) begin
            frameCnt_d = frameCnt_q + 32'd1;
        end
        if (runtHit && (runtCnt_q != 16'hFFFF)) begin
            runtCnt_d = runtCnt_q + 16'd1;
        end
    end

    assign s_rx_axis_tready = inReady;
    assign m_pl_axis_tdata  = outData_q;
    assign m_pl_axis_tkeep  = outKeep_q;
    assign m_pl_axis_tvalid = outValid_q;
    assign m_pl_axis_tlast  = outLast_q;
    assign m_pl_axis_tuser  = outUser_q;
    assign hdr_dst_mac      = hdrDst_q;
    assign hdr_src_mac      = hdrSrc_q;
    assign hdr_len_type     = hdrLen_q;
    assign hdr_valid        = hdrValid_q;
    assign frame_cnt        = frameCnt_q;
    assign runt_cnt         = runtCnt_q;

endmodule

// File: tb/tb_rx_eth_hdr_strip.sv
// Directed bench for rx_eth_hdr_strip: header capture, payload realignment, FLUSH,
// runt dropping, downstream backpressure and mid-frame reset.
module tb_rx_eth_hdr_strip;

    logic        clk = 1'b0;
    logic        axis_resetn;
    logic [63:0] s_rx_axis_tdata;
    logic [7:0]  s_rx_axis_tkeep;
    logic        s_rx_axis_tvalid;
    logic        s_rx_axis_tlast;
    logic        s_rx_axis_tuser;
    logic        s_rx_axis_tready;
    logic [63:0] m_pl_axis_tdata;
    logic [7:0]  m_pl_axis_tkeep;
    logic        m_pl_axis_tvalid;
    logic        m_pl_axis_tlast;
    logic        m_pl_axis_tuser;
    logic        m_pl_axis_tready;
    logic [47:0] hdr_dst_mac;
    logic [47:0] hdr_src_mac;
    logic [15:0] hdr_len_type;
    logic        hdr_valid;
    logic [31:0] frame_cnt;
    logic [15:0] runt_cnt;

    int assertCnt = 0;
    int failCnt   = 0;
    int readyLowCnt;
    int hdrValidCnt;

    logic [63:0] qData[$];
    logic [7:0]  qKeep[$];
    logic        qLast[$];
    logic        qUser[$];

    // dst = 1, src = 2, len_type = 30; first payload bytes 0x90, 0x91
    localparam logic [63:0] W0 = 64'h0002_0000_0000_0001;
    localparam logic [63:0] W1 = 64'h9190_001E_0000_0000;
    localparam logic [63:0] W2 = 64'hA7A6_A5A4_A3A2_A1A0;
    localparam logic [63:0] W3 = 64'hEEEE_B5B4_B3B2_B1B0;
    localparam logic [63:0] W2B = 64'hC7C6_C5C4_C3C2_C1C0;
    localparam logic [63:0] RUNT_W0 = 64'h0000_0000_0000_00AA;

    localparam logic [63:0] A_BEAT0 = 64'hA5A4_A3A2_A1A0_9190;
    localparam logic [63:0] A_BEAT1 = 64'hB5B4_B3B2_B1B0_A7A6;
    localparam logic [63:0] B_BEAT0 = 64'hC5C4_C3C2_C1C0_9190;
    localparam logic [63:0] B_BEAT1 = 64'h0000_0000_0000_C7C6;

    rx_eth_hdr_strip #(.DATA_WIDTH(64), .KEEP_WIDTH(8)) dut (
        .clk              (clk),
        .axis_resetn      (axis_resetn),
        .s_rx_axis_tdata  (s_rx_axis_tdata),
        .s_rx_axis_tkeep  (s_rx_axis_tkeep),
        .s_rx_axis_tvalid (s_rx_axis_tvalid),
        .s_rx_axis_tlast  (s_rx_axis_tlast),
        .s_rx_axis_tuser  (s_rx_axis_tuser),
        .s_rx_axis_tready (s_rx_axis_tready),
        .m_pl_axis_tdata  (m_pl_axis_tdata),
        .m_pl_axis_tkeep  (m_pl_axis_tkeep),
        .m_pl_axis_tvalid (m_pl_axis_tvalid),
        .m_pl_axis_tlast  (m_pl_axis_tlast),
        .m_pl_axis_tuser  (m_pl_axis_tuser),
        .m_pl_axis_tready (m_pl_axis_tready),
        .hdr_dst_mac      (hdr_dst_mac),
        .hdr_src_mac      (hdr_src_mac),
        .hdr_len_type     (hdr_len_type),
        .hdr_valid        (hdr_valid),
        .frame_cnt        (frame_cnt),
        .runt_cnt         (runt_cnt)
    );

    always #5 clk = ~clk;

    // Record each output handshake half a cycle before the edge that completes it.
    always @(negedge clk) begin
        if (axis_resetn) begin
            if (m_pl_axis_tvalid && m_pl_axis_tready) begin
                qData.push_back(m_pl_axis_tdata);
                qKeep.push_back(m_pl_axis_tkeep);
                qLast.push_back(m_pl_axis_tlast);
                qUser.push_back(m_pl_axis_tuser);
            end
            if (!s_rx_axis_tready && m_pl_axis_tready) readyLowCnt++;
            if (hdr_valid) hdrValidCnt++;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assertCnt++;
        if (actual !== expected) begin
            failCnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
        logic accepted;
        int   n;
        accepted = 1'b0;
        n = 0;
        s_rx_axis_tdata  = d;
        s_rx_axis_tkeep  = k;
        s_rx_axis_tlast  = l;
        s_rx_axis_tuser  = u;
        s_rx_axis_tvalid = 1'b1;
        while (!accepted && n < 50) begin
            @(negedge clk);
            accepted = s_rx_axis_tready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!accepted) checkOutput("input_accept_timeout", 64'd0, 64'd1);
        s_rx_axis_tvalid = 1'b0;
        s_rx_axis_tlast  = 1'b0;
        s_rx_axis_tuser  = 1'b0;
    endtask

    task automatic expectBeat(input string tag, input logic [63:0] d, input logic [7:0] k,
                              input logic l, input logic u);
        if (qData.size() == 0) begin
            checkOutput({tag, "_present"}, 64'd0, 64'd1);
        end else begin
            checkOutput({tag, "_data"}, qData.pop_front(), d);
            checkOutput({tag, "_keep"}, {56'd0, qKeep.pop_front()}, {56'd0, k});
            checkOutput({tag, "_last"}, {63'd0, qLast.pop_front()}, {63'd0, l});
            checkOutput({tag, "_user"}, {63'd0, qUser.pop_front()}, {63'd0, u});
        end
    endtask

    task automatic sendFrame30(input logic user);
        applyStimulus(W0, 8'hFF, 1'b0, 1'b0);
        applyStimulus(W1, 8'hFF, 1'b0, 1'b0);
        applyStimulus(W2, 8'hFF, 1'b0, 1'b0);
        applyStimulus(W3, 8'h3F, 1'b1, user);
    endtask

    initial begin
        axis_resetn      = 1'b0;
        s_rx_axis_tdata  = '0;
        s_rx_axis_tkeep  = '0;
        s_rx_axis_tvalid = 1'b0;
        s_rx_axis_tlast  = 1'b0;
        s_rx_axis_tuser  = 1'b0;
        m_pl_axis_tready = 1'b1;
        readyLowCnt      = 0;
        hdrValidCnt      = 0;
        waitCycles(3);
        axis_resetn = 1'b1;
        waitCycles(1);

        checkOutput("reset_tvalid", {63'd0, m_pl_axis_tvalid}, 64'd0);
        checkOutput("reset_frame_cnt", {32'd0, frame_cnt}, 64'd0);
        checkOutput("reset_runt_cnt", {48'd0, runt_cnt}, 64'd0);
        checkOutput("reset_hdr_dst", {16'd0, hdr_dst_mac}, 64'd0);
        checkOutput("reset_in_ready", {63'd0, s_rx_axis_tready}, 64'd1);

        // 30-byte good frame: two full output beats, no FLUSH cycle
        readyLowCnt = 0;
        hdrValidCnt = 0;
        sendFrame30(1'b1);
        waitCycles(3);
        expectBeat("f30_beat0", A_BEAT0, 8'hFF, 1'b0, 1'b0);
        expectBeat("f30_beat1", A_BEAT1, 8'hFF, 1'b1, 1'b1);
        checkOutput("f30_extra_beats", qData.size(), 64'd0);
        checkOutput("f30_frame_cnt", {32'd0, frame_cnt}, 64'd1);
        checkOutput("f30_no_flush", readyLowCnt, 64'd0);
        checkOutput("hdr_valid_pulses", hdrValidCnt, 64'd1);
        checkOutput("hdr_dst", {16'd0, hdr_dst_mac}, 64'h1);
        checkOutput("hdr_src", {16'd0, hdr_src_mac}, 64'h2);
        checkOutput("hdr_len_type", {48'd0, hdr_len_type}, 64'd30);

        // 24-byte frame: last input beat has 8 bytes, so a FLUSH beat follows
        readyLowCnt = 0;
        applyStimulus(W0, 8'hFF, 1'b0, 1'b0);
        applyStimulus(W1, 8'hFF, 1'b0, 1'b0);
        applyStimulus(W2B, 8'hFF, 1'b1, 1'b1);
        waitCycles(3);
        expectBeat("f24_beat0", B_BEAT0, 8'hFF, 1'b0, 1'b0);
        expectBeat("f24_flush", B_BEAT1, 8'h03, 1'b1, 1'b1);
        checkOutput("f24_flush_ready_low", readyLowCnt, 64'd1);
        checkOutput("f24_frame_cnt", {32'd0, frame_cnt}, 64'd2);

        // Runts: one-beat frame, then a frame ending exactly at the header
        hdrValidCnt = 0;
        applyStimulus(RUNT_W0, 8'hFF, 1'b1, 1'b1);
        waitCycles(1);
        checkOutput("runt1_cnt", {48'd0, runt_cnt}, 64'd1);
        applyStimulus(RUNT_W0, 8'hFF, 1'b0, 1'b0);
        applyStimulus(W1, 8'h3F, 1'b1, 1'b1);
        waitCycles(3);
        checkOutput("runt2_cnt", {48'd0, runt_cnt}, 64'd2);
        checkOutput("runt_no_payload", qData.size(), 64'd0);
        checkOutput("runt_no_hdr_valid", hdrValidCnt, 64'd0);
        checkOutput("runt_hdr_dst_held", {16'd0, hdr_dst_mac}, 64'h1);
        checkOutput("runt_frame_cnt", {32'd0, frame_cnt}, 64'd2);

        // Downstream stall for 5 cycles while beat 0 sits in the output register
        applyStimulus(W0, 8'hFF, 1'b0, 1'b0);
        applyStimulus(W1, 8'hFF, 1'b0, 1'b0);
        applyStimulus(W2, 8'hFF, 1'b0, 1'b0);
        m_pl_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            waitCycles(1);
            checkOutput("stall_in_ready", {63'd0, s_rx_axis_tready}, 64'd0);
            checkOutput("stall_data_hold", m_pl_axis_tdata, A_BEAT0);
            checkOutput("stall_valid_hold", {63'd0, m_pl_axis_tvalid}, 64'd1);
        end
        m_pl_axis_tready = 1'b1;
        applyStimulus(W3, 8'h3F, 1'b1, 1'b0);
        waitCycles(3);
        expectBeat("stall_beat0", A_BEAT0, 8'hFF, 1'b0, 1'b0);
        expectBeat("stall_beat1", A_BEAT1, 8'hFF, 1'b1, 1'b0);
        checkOutput("stall_extra_beats", qData.size(), 64'd0);
        checkOutput("stall_frame_cnt", {32'd0, frame_cnt}, 64'd3);

        // Reset in the middle of a frame body, then a clean 30-byte frame
        applyStimulus(W0, 8'hFF, 1'b0, 1'b0);
        applyStimulus(W1, 8'hFF, 1'b0, 1'b0);
        applyStimulus(W2, 8'hFF, 1'b0, 1'b0);
        axis_resetn = 1'b0;
        #1;
        checkOutput("midrst_tvalid", {63'd0, m_pl_axis_tvalid}, 64'd0);
        checkOutput("midrst_tdata", m_pl_axis_tdata, 64'd0);
        checkOutput("midrst_frame_cnt", {32'd0, frame_cnt}, 64'd0);
        checkOutput("midrst_runt_cnt", {48'd0, runt_cnt}, 64'd0);
        checkOutput("midrst_hdr_src", {16'd0, hdr_src_mac}, 64'd0);
        waitCycles(2);
        axis_resetn = 1'b1;
        waitCycles(1);
        checkOutput("midrst_no_payload", qData.size(), 64'd0);
        hdrValidCnt = 0;
        sendFrame30(1'b1);
        waitCycles(3);
        expectBeat("post_rst_beat0", A_BEAT0, 8'hFF, 1'b0, 1'b0);
        expectBeat("post_rst_beat1", A_BEAT1, 8'hFF, 1'b1, 1'b1);
        checkOutput("post_rst_frame_cnt", {32'd0, frame_cnt}, 64'd1);
        checkOutput("post_rst_hdr_valid", hdrValidCnt, 64'd1);
        checkOutput("post_rst_hdr_len", {48'd0, hdr_len_type}, 64'd30);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
